// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
// RV32I load/store size codes, FSM states and byte-enable helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_state_t;

  function automatic logic [3:0] byte_en(
    input logic [2:0] funct3,
    input logic [1:0] addr_lo
  );
    logic [3:0] m;
    m = 4'b0000;
    case (funct3)
      F3_B, F3_BU: m = 4'b0001 << addr_lo;
      F3_H, F3_HU: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension.
// Purely combinational so it can sit behind any word source.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_i[{addr_lo_i, 3'b000} +: 8];
    h = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{b[7]}}, b};
      F3_BU:   data_o = {24'h0, b};
      F3_H:    data_o = {{16{h[15]}}, h};
      F3_HU:   data_o = {16'h0, h};
      F3_W:    data_o = word_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store data memory with valid/ready request and a one-cycle
// response pulse; stores commit on accept, loads return after a fixed latency.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
  parameter int          READ_LATENCY  = 2,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IW       = ADDR_WIDTH - 2;
  localparam int          DEPTH    = 1 << IW;
  localparam logic [31:0] SPAN     = 32'(64'd1 << ADDR_WIDTH);
  localparam logic [1:0]  CNT_INIT = 2'(READ_LATENCY - 2);

  logic [31:0] mem [DEPTH];

  mem_state_t  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]  lo_q, lo_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]   offset;
  logic [IW-1:0] req_idx;
  logic          in_range;
  logic          f3_ok;
  logic          misalign;
  logic          req_err;
  logic          accept;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wlane;

  logic          use_req;
  logic [IW-1:0] rd_idx;
  logic [1:0]    rd_lo;
  logic [2:0]    rd_f3;
  logic [31:0]   rd_word;
  logic [31:0]   aligned;

  assign req_ready  = (state_q != BUSY) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign offset   = req_addr - BASE_ADDR;
  assign req_idx  = offset[ADDR_WIDTH-1:2];
  assign in_range = (req_addr >= BASE_ADDR) && (offset < SPAN);

  always_comb begin
    f3_ok    = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    misalign = 1'b0;
    unique case (1'b1)
      (req_funct3 == F3_H) || (req_funct3 == F3_HU):
        misalign = req_addr[0];
      (req_funct3 == F3_W):
        misalign = (req_addr[1:0] != 2'b00);
      default:
        misalign = 1'b0;
    endcase
    req_err = !f3_ok || misalign || !in_range
            || (req_write && req_funct3[2]);
  end

  // Replicate the low byte/half so byte enables pick the right lane.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   wlane = {4{req_wdata[7:0]}};
      2'b01:   wlane = {2{req_wdata[15:0]}};
      default: wlane = req_wdata;
    endcase
  end

  assign be = byte_en(req_funct3, req_addr[1:0]);
  assign we = accept && req_write && !req_err;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[req_idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign use_req = (state_q != BUSY);
  assign rd_idx  = use_req ? req_idx : idx_q;
  assign rd_lo   = use_req ? req_addr[1:0] : lo_q;
  assign rd_f3   = use_req ? req_funct3 : f3_q;
  assign rd_word = mem[rd_idx];

  load_align u_align (
    .word_i    (rd_word),
    .addr_lo_i (rd_lo),
    .funct3_i  (rd_f3),
    .data_o    (aligned)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      BUSY: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
          rdata_d = aligned;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      idx_d = req_idx;
      lo_d  = req_addr[1:0];
      f3_d  = req_funct3;
      if (req_write || req_err) begin
        state_d = RESP;
        rdata_d = 32'h0;
        err_d   = req_err;
      end else if (READ_LATENCY == 1) begin
        state_d = RESP;
        rdata_d = aligned;
        err_d   = 1'b0;
      end else begin
        state_d = BUSY;
        cnt_d   = CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      idx_q   <= '0;
      lo_q    <= 2'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
